// File: rtl/haraka_s_digest_rx_if.sv
// Byte-in / word-out bus of the Haraka-S digest receiver.
// slave: the receiver. master: the side driving bytes and consuming words.
interface haraka_s_digest_rx_if #(
  parameter int unsigned LEN_W = 64
);
  logic             start;
  logic [LEN_W-1:0] digest_length;
  logic [7:0]       serial_in;
  logic             byte_valid;
  logic [31:0]      word_out;
  logic [3:0]       word_keep;
  logic             word_last;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             done;
  logic             overflow;

  modport slave (
    input  start, digest_length, serial_in, byte_valid, word_ready,
    output word_out, word_keep, word_last, word_valid, busy, done, overflow
  );

  modport master (
    output start, digest_length, serial_in, byte_valid, word_ready,
    input  word_out, word_keep, word_last, word_valid, busy, done, overflow
  );
endinterface

// File: rtl/haraka_s_digest_rx.sv
// Haraka-S digest receiver: packs the squeeze byte stream into big-endian
// 32-bit words, masks the trailing partial byte, and queues words in a
// first-word fall-through FIFO with a valid/ready output.
module haraka_s_digest_rx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 64
) (
  input logic                 clk,
  input logic                 reset,
  haraka_s_digest_rx_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = LEN_W - 2;
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];
  localparam logic [PW:0] ONE_C   = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_nbytes;
  logic [CW-1:0]   r_byte_cnt;
  logic [2:0]      r_rem;
  logic [31:0]     r_asm;
  logic [31:0]     r_mem_data [FIFO_DEPTH];
  logic [3:0]      r_mem_keep [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;
  logic            r_overflow;

  logic [CW-1:0]   w_nbytes;
  logic            w_len_zero;
  logic            w_accept;
  logic [1:0]      w_slot;
  logic            w_is_last;
  logic [7:0]      w_tail_mask;
  logic [7:0]      w_byte;
  logic [4:0]      w_shift;
  logic [31:0]     w_word;
  logic [3:0]      w_keep;
  logic            w_push;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_drop;

  assign w_len_zero  = (bus.digest_length == '0);
  assign w_nbytes    = CW'(bus.digest_length[LEN_W-1:3]) + CW'(|bus.digest_length[2:0]);
  assign w_accept    = (r_state == S_COLLECT) && bus.byte_valid && !bus.start;
  assign w_slot      = r_byte_cnt[1:0];
  assign w_is_last   = (r_byte_cnt == r_nbytes - CW'(1));
  assign w_tail_mask = (r_rem == 3'd0) ? 8'hFF : ~(8'hFF >> r_rem);
  assign w_byte      = w_is_last ? (bus.serial_in & w_tail_mask) : bus.serial_in;
  assign w_shift     = {2'd3 - w_slot, 3'b000};
  assign w_word      = r_asm | ({24'h0, w_byte} << w_shift);
  assign w_keep      = ~(4'b0111 >> w_slot);
  assign w_push      = w_accept && ((w_slot == 2'd3) || w_is_last);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = !w_empty && bus.word_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  assign bus.word_valid = !w_empty;
  assign bus.word_out   = w_empty ? '0 : r_mem_data[r_rptr];
  assign bus.word_keep  = w_empty ? '0 : r_mem_keep[r_rptr];
  assign bus.word_last  = w_empty ? 1'b0 : r_mem_last[r_rptr];
  assign bus.busy       = (r_state == S_COLLECT) || (r_state == S_DRAIN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.overflow   = r_overflow;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; start overrides everything and restarts the digest.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.start) begin
      w_state_nxt = w_len_zero ? S_DONE : S_COLLECT;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_IDLE;
        S_COLLECT: if (w_accept && w_is_last) w_state_nxt = S_DRAIN;
        // Leave as soon as the last queued word is being popped.
        S_DRAIN:   if (w_empty || ((r_count == ONE_C) && w_pop)) w_state_nxt = S_DONE;
        S_DONE:    w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Length latch, byte counter and word assembler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nbytes   <= '0;
      r_rem      <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (bus.start) begin
      r_nbytes   <= w_nbytes;
      r_rem      <= bus.digest_length[2:0];
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (w_accept) begin
      r_byte_cnt <= r_byte_cnt + CW'(1);
      r_asm      <= w_push ? '0 : w_word;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.start) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_data[r_wptr] <= w_word;
      r_mem_keep[r_wptr] <= w_keep;
      r_mem_last[r_wptr] <= w_is_last;
    end
  end
endmodule

// File: tb/tb_haraka_s_digest_rx.sv
// Self-checking bench for haraka_s_digest_rx: directed and random digests
// compared every cycle against a queue-based reference model.
module tb_haraka_s_digest_rx;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  haraka_s_digest_rx_if #(.LEN_W(64)) bus ();

  haraka_s_digest_rx #(.FIFO_DEPTH(DEPTH), .LEN_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } wexp_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] tx[$];
  wexp_t      exp_list[$];
  wexp_t      mq[$];
  int         m_n;
  int         m_cnt;
  bit         m_coll, m_drain, m_done, m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word sequence for a digest of len bits built from tx.
  task automatic build_expected(input logic [63:0] len);
    int r;
    int w;
    logic [7:0] b;
    exp_list.delete();
    m_n = int'((len + 64'd7) / 64'd8);
    r = int'(len % 64'd8);
    w = (m_n + 3) / 4;
    for (int k = 0; k < w; k++) begin
      wexp_t e;
      e.d = 32'h0;
      e.k = 4'b0000;
      e.l = (k == w - 1);
      for (int j = 0; j < 4; j++) begin
        int idx = 4 * k + j;
        if (idx < m_n) begin
          b = (idx < tx.size()) ? tx[idx] : 8'h00;
          if (idx == m_n - 1 && r != 0) b = b & 8'(256 - (1 << (8 - r)));
          e.d = e.d + (32'(b) * (32'd1 << (8 * (3 - j))));
          e.k[3 - j] = 1'b1;
        end
      end
      exp_list.push_back(e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_coll = 0; m_drain = 0; m_done = 0; m_ovf = 0; m_cnt = 0;
  endtask

  // One clock: drive inputs, check the word leaving (if any), advance the
  // model, then check status outputs after the edge.
  task automatic tick(input bit st, input logic [63:0] len, input bit bv,
                      input logic [7:0] b, input bit rdy);
    bit pop;
    bit nd;
    bus.start = st;
    bus.digest_length = len;
    bus.byte_valid = bv;
    bus.serial_in = b;
    bus.word_ready = rdy;
    pop = 0;
    if (!st && mq.size() != 0 && rdy) begin
      chk("word_out", bus.word_out, mq[0].d);
      chk("word_keep", bus.word_keep, mq[0].k);
      chk("word_last", bus.word_last, mq[0].l);
      pop = 1;
    end
    if (st) begin
      model_reset();
      build_expected(len);
      if (len == 0) m_done = 1;
      else          m_coll = 1;
    end else begin
      nd = 0;
      if (pop) void'(mq.pop_front());
      if (m_coll && bv) begin
        m_cnt++;
        if (m_cnt % 4 == 0 || m_cnt == m_n) begin
          if (mq.size() < DEPTH) mq.push_back(exp_list[(m_cnt - 1) / 4]);
          else m_ovf = 1;
        end
        if (m_cnt == m_n) begin
          m_coll = 0;
          m_drain = 1;
        end
      end else if (m_drain && mq.size() == 0) begin
        m_drain = 0;
        nd = 1;
      end
      m_done = nd;
    end
    @(negedge clk);
    chk("word_valid", bus.word_valid, mq.size() != 0);
    chk("busy", bus.busy, m_coll || m_drain);
    chk("done", bus.done, m_done);
    chk("overflow", bus.overflow, m_ovf);
  endtask

  function automatic bit rdy_for(input int mode, input int i, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      2:       return 1'b0;
      default: return (i == n - 1);
    endcase
  endfunction

  // mode: 0 ready high, 1 random ready, 2 ready low while sending,
  // 3 ready low until the final byte.
  task automatic send_digest(input logic [63:0] len, input int nsend, input int mode,
                             input bit gaps, input bit wait_done);
    int guard;
    tick(1'b1, len, 1'b0, 8'h00, mode == 0);
    for (int i = 0; i < nsend; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick(1'b0, len, 1'b0, 8'h00, (mode == 3) ? 1'b0 : rdy_for(mode, i, nsend));
      tick(1'b0, len, 1'b1, tx[i], rdy_for(mode, i, nsend));
    end
    if (wait_done) begin
      guard = 0;
      while ((m_coll || m_drain || m_done) && guard < 300) begin
        tick(1'b0, len, 1'b0, 8'h00, (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
        guard++;
      end
      if (guard >= 300) begin
        n_cmp++;
        n_err++;
        $error("FAIL drain_timeout observed=busy expected=idle within 300 cycles");
      end
    end
  endtask

  initial begin
    int n;
    logic [63:0] len;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.digest_length = '0;
    bus.serial_in = '0;
    bus.byte_valid = 1'b0;
    bus.word_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_word_out", bus.word_out, 32'h0);
    chk("rst_word_keep", bus.word_keep, 4'h0);
    chk("rst_word_last", bus.word_last, 1'b0);
    chk("rst_word_valid", bus.word_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 256-bit digest, bytes 00..1F, ready always high
    tx.delete();
    for (int i = 0; i < 32; i++) tx.push_back(8'(i));
    send_digest(64'd256, 32, 0, 1'b0, 1'b1);

    // 20-bit digest: AA BB CC -> AABBC000, trailing DD ignored
    tx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_digest(64'd20, 4, 0, 1'b0, 1'b1);

    // zero-length digest
    tx.delete();
    send_digest(64'd0, 0, 0, 1'b0, 1'b1);

    // overflow: 5 words into a 4-deep FIFO with ready low
    tx.delete();
    for (int i = 0; i < 20; i++) tx.push_back(8'($urandom));
    send_digest(64'd160, 20, 2, 1'b0, 1'b1);

    // full FIFO with push and pop together: no overflow, last delivered
    tx.delete();
    for (int i = 0; i < 20; i++) tx.push_back(8'($urandom));
    send_digest(64'd160, 20, 3, 1'b0, 1'b1);

    // asynchronous reset after 5 bytes of a 64-bit digest
    tx.delete();
    for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
    send_digest(64'd64, 5, 0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_word_out", bus.word_out, 32'h0);
    chk("mid_rst_word_keep", bus.word_keep, 4'h0);
    chk("mid_rst_word_last", bus.word_last, 1'b0);
    chk("mid_rst_word_valid", bus.word_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_overflow", bus.overflow, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick(1'b0, 64'd0, 1'b1, 8'($urandom), 1'b1);
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_digest(64'd32, 4, 0, 1'b0, 1'b1);

    // restart after 3 bytes; the partial word must vanish
    tx.delete();
    for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
    send_digest(64'd64, 3, 0, 1'b0, 1'b0);
    tx = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_digest(64'd32, 4, 0, 1'b0, 1'b1);

    // random lengths, gaps and backpressure
    for (int k = 0; k < 8; k++) begin
      len = 64'($urandom_range(1, 200));
      n = int'((len + 64'd7) / 64'd8);
      tx.delete();
      for (int i = 0; i < n + 2; i++) tx.push_back(8'($urandom));
      send_digest(len, n + 1, 1, 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/haraka_s_digest_rx.md
# haraka_s_digest_rx

Receive-side counterpart of the Haraka-S squeeze path: it accepts the 8-bit digest byte stream emitted by the sponge core's serializer and reassembles it into 32-bit big-endian words. The block tracks the requested digest length, masks the trailing partial byte and partial word, and buffers words in a small FIFO. Words are presented to the downstream consumer over a valid/ready handshake. It sits between the Haraka_S core output and the host/bus interface.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of 32-bit word entries; power of two, ≥2
- LEN_W, 64, width of digest_length (bits)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches digest_length, clears counters/FIFO/overflow, enters COLLECT
- digest_length  in  LEN_W  requested digest length in bits, sampled only on start
- serial_in  in  8  digest byte from core
- byte_valid  in  1  serial_in holds a valid byte this cycle (no backpressure to core)
- word_out  out  32  FIFO head word, first byte in [31:24]
- word_keep  out  4  valid-byte mask of word_out, bit 3 = [31:24]
- word_last  out  1  word_out is the final digest word
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts word_out when word_valid && word_ready
- busy  out  1  state is COLLECT or DRAIN
- done  out  1  one-cycle pulse, digest fully delivered
- overflow  out  1  sticky; a word was dropped because FIFO was full

## Operation
- Derived at start: N = ceil(digest_length/8) bytes, r = digest_length[2:0], W = ceil(N/4) words. Counters are at least LEN_W-3 bits wide; no wrap within legal range.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE: bytes ignored. start → COLLECT; if digest_length==0 → DONE.
  - COLLECT: each byte_valid byte is shifted into the word assembler at slot (byte_cnt mod 4), MSB slot first.
    - The byte with index N-1 and r≠0 is ANDed with a mask keeping its top r bits (e.g. r=4 → 0xF0).
    - A word is pushed when the 4th slot fills or byte N-1 is accepted. Unfilled slots are zero; keep = filled slots; last = 1 on the push of byte N-1.
    - After byte N-1 → DRAIN. Further bytes are ignored.
  - DRAIN: wait until FIFO empty → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Push while FIFO full and no simultaneous pop: word dropped, overflow←1, counters still advance. Push and pop in the same cycle while full is legal and does not overflow.
- start in any state aborts the current digest: FIFO flushed, assembler cleared, overflow cleared, new length latched. A byte_valid in the start cycle is ignored.
- If the last word is dropped, done still pulses after the FIFO empties; word_last is never seen. Overflow flags this case.

## Timing
- Reset values: word_out=0, word_keep=0, word_last=0, word_valid=0, busy=0, done=0, overflow=0; state IDLE, FIFO empty.
- Reset mid-operation returns to these values immediately (asynchronous). Nothing resumes until the next start.
- Byte to FIFO latency: the completing byte is accepted in cycle t; word_valid (if FIFO was empty) rises at t+1.
- FIFO is registered, first-word fall-through. word_out, word_keep and word_last are stable while word_valid && !word_ready.
- done asserts the cycle after the pop that empties the FIFO in DRAIN.
- digest_length==0: start at t, done at t+1, no words.
- busy rises the cycle after start and falls in the DONE cycle.
- Throughput: one byte per cycle sustained; one word popped per cycle.

## Test plan
- len=256, bytes 0x00..0x1F back-to-back, ready=1 → 8 words 0x00010203..0x1C1D1E1F, keep=4'b1111 each, last only on the 8th, done one cycle after the last pop.
- len=20, bytes AA BB CC → one word 0xAABBC000, keep=4'b1110, last=1; a 4th byte DD is ignored; done pulses.
- len=0 start → done at t+1, word_valid never asserts, busy stays 0.
- len=160, 20 bytes, word_ready=0 with FIFO_DEPTH=4 → 4 words stored, 5th dropped, overflow=1. Raising ready drains 0x..., last never asserted; done after drain; next start clears overflow.
- len=64, reset asserted after 5 bytes → all outputs 0 in the same cycle. Following bytes are ignored; a new start with len=32 and bytes 11 22 33 44 → 0x11223344, last=1.
- len=64, restart with start after 3 bytes (len=32) → no partial word emitted; bytes 55 66 77 88 → single word 0x55667788, keep 4'b1111, last=1.
